// File: rtl/csela_pkg.sv
// rtl/csela_pkg.sv - shared constants and types for the wide add/subtract sequencer
package csela_pkg;

  localparam int WORD_W = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/csela32_cin.sv
// rtl/csela32_cin.sv - combinational 32-bit carry-select adder with carry-in
module csela32_cin
  import csela_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  localparam int NB = WORD_W / 4;

  logic [NB:0] c;

  assign c[0] = cin;

  // Each 4-bit block computes both carry-in outcomes; the incoming carry only drives muxes.
  for (genvar i = 0; i < NB; i++) begin : g_blk
    logic [4:0] r0;
    logic [4:0] r1;

    assign r0 = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]};
    assign r1 = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + 5'd1;

    assign sum[4*i +: 4] = c[i] ? r1[3:0] : r0[3:0];
    assign c[i+1]        = c[i] ? r1[4]   : r0[4];
  end

  assign cout = c[NB];

endmodule

// File: rtl/csela_wide_seq.sv
// rtl/csela_wide_seq.sv - multi-cycle wide add/subtract over one shared 32-bit adder
module csela_wide_seq
  import csela_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    op_sub,
  input  logic [WORD_W*WORDS-1:0] a,
  input  logic [WORD_W*WORDS-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*WORDS-1:0] sum,
  output logic                    cout,
  output logic                    ovf,
  output logic                    busy
);

  localparam int W  = WORD_W * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  state_t state, state_n;

  logic [W-1:0]      a_r;
  logic [W-1:0]      b_r;
  logic              carry;
  logic [KW-1:0]     k;
  logic [W-1:0]      sum_r;
  logic              cout_r;
  logic              ovf_r;

  logic [WORD_W-1:0] slice_a;
  logic [WORD_W-1:0] slice_b;
  logic [WORD_W-1:0] slice_s;
  logic              slice_c;
  logic              is_last;

  assign slice_a = a_r[int'(k)*WORD_W +: WORD_W];
  assign slice_b = b_r[int'(k)*WORD_W +: WORD_W];
  assign is_last = (k == K_LAST);

  csela32_cin u_add (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_s),
    .cout (slice_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = RUN;
      RUN:     if (is_last) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Subtract is a + ~b + 1: the carry register seeds the +1 on the first slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      carry  <= 1'b0;
      k      <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= (op_sub == OP_SUB) ? ~b : b;
            carry <= op_sub;
            k     <= '0;
          end
        end
        RUN: begin
          sum_r[int'(k)*WORD_W +: WORD_W] <= slice_s;
          carry <= slice_c;
          k     <= k + KW'(1);
          if (is_last) begin
            cout_r <= slice_c;
            ovf_r  <= (a_r[W-1] == b_r[W-1]) && (slice_s[WORD_W-1] != a_r[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_csela_wide_seq.sv
// tb/tb_csela_wide_seq.sv - directed self-checking bench for csela_wide_seq (WORDS=4)
module tb_csela_wide_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [127:0] a;
  logic [127:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int lat;

  localparam logic [127:0] ONES = {128{1'b1}};

  always #5 clk = ~clk;

  csela_wide_seq #(.WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one op, count edges from the accept edge until out_valid is seen.
  task automatic start_and_wait(input logic sub, input logic [127:0] aa, input logic [127:0] bb);
    chk("pre_in_ready", 128'(in_ready), 128'd1);
    op_sub   = sub;
    a        = aa;
    b        = bb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_result;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_out_valid", 128'(out_valid), 128'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b0;

    tick();
    tick();
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_sum", sum, 128'd0);
    chk("rst_cout", 128'(cout), 128'd0);
    chk("rst_ovf", 128'(ovf), 128'd0);
    rst = 1'b0;
    tick();

    // Full carry ripple across all four slices
    start_and_wait(1'b0, ONES, 128'd1);
    chk("ripple_latency", 128'(lat), 128'd5);
    chk("ripple_sum", sum, 128'd0);
    chk("ripple_cout", 128'(cout), 128'd1);
    chk("ripple_ovf", 128'(ovf), 128'd0);
    release_result();

    start_and_wait(1'b0, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1);
    chk("mid_latency", 128'(lat), 128'd5);
    chk("mid_sum", sum, 128'h00000000_00000001_00000000_00000000);
    chk("mid_cout", 128'(cout), 128'd0);
    chk("mid_ovf", 128'(ovf), 128'd0);
    release_result();

    start_and_wait(1'b1, 128'd0, 128'd1);
    chk("sub0_sum", sum, ONES);
    chk("sub0_cout", 128'(cout), 128'd0);
    chk("sub0_ovf", 128'(ovf), 128'd0);
    release_result();

    start_and_wait(1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd1);
    chk("subovf_sum", sum, 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    chk("subovf_cout", 128'(cout), 128'd1);
    chk("subovf_ovf", 128'(ovf), 128'd1);
    release_result();

    // Backpressure: result held while a new op waits at the input
    start_and_wait(1'b0, 128'd2, 128'd3);
    chk("bp_latency", 128'(lat), 128'd5);
    op_sub   = 1'b0;
    a        = 128'd7;
    b        = 128'd9;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_sum", sum, 128'd5);
      chk("bp_cout", 128'(cout), 128'd0);
      chk("bp_ovf", 128'(ovf), 128'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_hs_busy", 128'(busy), 128'd0);
    chk("bp_hs_in_ready", 128'(in_ready), 128'd1);
    chk("bp_hs_sum_hold", sum, 128'd5);
    tick();
    in_valid = 1'b0;
    chk("bp_second_accept", 128'(busy), 128'd1);
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("bp2_latency", 128'(lat), 128'd5);
    chk("bp2_sum", sum, 128'd16);
    release_result();

    // Reset during the second RUN cycle aborts the op
    op_sub   = 1'b0;
    a        = 128'd100;
    b        = 128'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("abort_busy_run", 128'(busy), 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_sum", sum, 128'd0);
    chk("abort_in_ready", 128'(in_ready), 128'd1);

    start_and_wait(1'b0, 128'd5, 128'd3);
    chk("after_abort_latency", 128'(lat), 128'd5);
    chk("after_abort_sum", sum, 128'd8);
    chk("after_abort_cout", 128'(cout), 128'd0);
    release_result();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csela_wide_seq.md
# csela_wide_seq

Multi-cycle wide-operand add/subtract sequencer built around one shared 32-bit carry-select adder. The block accepts a WORDS×32-bit operand pair over a valid/ready handshake. It feeds one 32-bit slice per cycle through the adder, least-significant word first, and chains the carry through a register between slices. It returns the full sum, carry-out and signed overflow over a second valid/ready handshake. It is the sequencing layer that lets the adder-benchmark datapath handle 64/128/256-bit arithmetic without replicating adder hardware.

## Interface
- WORDS, 4, number of 32-bit slices per operand; legal range 2..8
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair and op are valid
- in_ready  out  1  block can accept an operation
- op_sub  in  1  0 = a+b, 1 = a−b
- a  in  32·WORDS  operand A
- b  in  32·WORDS  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  32·WORDS  result
- cout  out  1  carry out of the MSB; for subtract, 1 = no borrow
- ovf  out  1  two's-complement signed overflow
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE: in_ready=1.
  - An accept happens when in_valid&&in_ready.
  - On accept, latch a, the effective b (b, or ~b when op_sub=1) and op_sub.
  - Set the carry register to op_sub and the slice counter k to 0, then go to RUN.
- RUN: each cycle presents slice k of a and effective b to the adder, with the carry register as carry-in.
  - Write the adder sum into sum[32k+31:32k].
  - Load the adder carry-out into the carry register.
  - Increment k.
  - In the cycle k=WORDS−1: capture cout from the adder carry-out, set ovf = (a_msb == beff_msb) && (sum_msb != a_msb), and go to DONE.
- DONE: out_valid=1.
  - On out_ready, go to IDLE.
  - in_ready stays 0 in DONE, so there is no same-cycle accept; the next accept is possible the following cycle.
- Signals ignored outside IDLE: in_valid and the operand inputs.
- Signals ignored outside DONE: out_ready.
- Arithmetic: modulo 2^(32·WORDS). The counter is clog2(WORDS) bits wide and does not wrap inside RUN because the exit happens at WORDS−1.
- Reset: all states and registers are cleared.
  - Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
  - Reset during RUN or DONE aborts the operation; no result is emitted.

## Timing
- Accept at edge t. RUN occupies cycles t+1 … t+WORDS. out_valid rises at t+WORDS+1.
- Latency from accept to out_valid is WORDS+1 cycles.
- Best-case throughput is one operation per WORDS+2 cycles.
- sum, cout and ovf are registered outputs. They are stable for the whole time out_valid=1 and hold their last values after the handshake until the next op writes them.
- During RUN, sum slices above k hold stale data; this is legal because out_valid=0.
- The adder path is combinational from registered slice and carry to a register, i.e. one adder delay per cycle.

## Structure
- Shared package csela_pkg:
  - WORD_W=32
  - FSM state enum (IDLE/RUN/DONE)
  - op encoding constants (OP_ADD=0, OP_SUB=1)
- Sub-module csela32_cin: 32-bit carry-select adder with carry-in. It is purely combinational, 4-bit blocks, dual-rail precompute with a mux on carry. It is instantiated once.
- The sequencer holds the operand registers, carry register, counter, FSM and result register.

## Test plan
All scenarios use WORDS=4.
- Reset: assert rst for 2 cycles -> in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
- Full carry ripple: a=all ones (128'hFFFF…F), b=1, add -> out_valid exactly 5 cycles after accept, sum=0, cout=1, ovf=0.
- Mid carry: a=128'h0…0_FFFFFFFF_FFFFFFFF, b=1, add -> sum=128'h00000000_00000001_00000000_00000000, cout=0, ovf=0.
- Subtract:
  - 0−1 -> sum=all ones, cout=0, ovf=0.
  - 128'h8000…0 − 1 -> sum=128'h7FFF…F, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid while in_valid=1 with new operands -> sum/cout/ovf unchanged, in_ready=0, and no second accept until one cycle after the out_ready handshake.
- Reset mid-RUN: assert rst in the 2nd RUN cycle -> next cycle state is IDLE with out_valid=0 and sum=0. A following op 5+3 yields sum=8 with normal latency.
